// File: rtl/trng_sampler.sv
// trng_sampler: ring-oscillator entropy front end.
// Synchronise and decimate the raw bit, von Neumann debias, repetition-count health test, pack words.
module trng_sampler #(
  parameter int WORD_W     = 32,
  parameter int SAMPLE_DIV = 8,
  parameter int WARMUP     = 16,
  parameter int REP_LIMIT  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              RAW_ENTROPY_IN,
  output logic              OSC_RESET,
  output logic [WORD_W-1:0] WORD_OUT,
  output logic              WORD_VALID,
  input  logic              WORD_READY,
  output logic              HEALTH_FAIL
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int BC_W   = $clog2(WORD_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [REP_W-1:0]  REP_TRIP  = REP_W'(REP_LIMIT);
  localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL
  } state_t;

  state_t state_q, state_nxt;

  logic [1:0]        sync_pipe;
  logic              raw_s;
  logic [DIV_W-1:0]  div_q;
  logic [WARM_W-1:0] warm_q;
  logic [REP_W-1:0]  rep_q, rep_nxt;
  logic              prev_q, first_q;
  logic              phase_q, a_q;
  logic [BC_W-1:0]   bits_q;
  logic [WORD_W-1:0] shift_q, shift_nxt;

  logic run, tick, entering, trip, warm_done, bit_vld, word_done, xfer;
  logic osc_nxt, valid_nxt, fail_nxt;

  assign raw_s     = sync_pipe[1];
  assign run       = (state_q == S_WARMUP) || (state_q == S_COLLECT);
  assign tick      = run && (div_q == DIV_LAST);
  assign rep_nxt   = (first_q || (raw_s != prev_q)) ? REP_W'(1) : rep_q + REP_W'(1);
  assign trip      = tick && (rep_nxt == REP_TRIP);
  assign warm_done = tick && (warm_q == WARM_LAST);
  assign bit_vld   = tick && (state_q == S_COLLECT) && phase_q && (a_q != raw_s);
  assign word_done = bit_vld && (bits_q == BIT_LAST);
  assign shift_nxt = {shift_q[WORD_W-2:0], a_q};
  assign xfer      = (state_q == S_HOLD) && WORD_VALID && WORD_READY;
  assign entering  = (state_nxt != state_q) &&
                     ((state_nxt == S_WARMUP) || (state_nxt == S_COLLECT));

  // State register and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      OSC_RESET   <= 1'b1;
      WORD_VALID  <= 1'b0;
      HEALTH_FAIL <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      OSC_RESET   <= osc_nxt;
      WORD_VALID  <= valid_nxt;
      HEALTH_FAIL <= fail_nxt;
    end
  end

  // Next state: health trip beats ENABLE drop beats word completion
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:
        if (ENABLE) state_nxt = (WARMUP == 0) ? S_COLLECT : S_WARMUP;
      S_WARMUP:
        if (trip)           state_nxt = S_FAIL;
        else if (!ENABLE)   state_nxt = S_IDLE;
        else if (warm_done) state_nxt = S_COLLECT;
      S_COLLECT:
        if (trip)           state_nxt = S_FAIL;
        else if (!ENABLE)   state_nxt = S_IDLE;
        else if (word_done) state_nxt = S_HOLD;
      S_HOLD:
        if (xfer) state_nxt = ENABLE ? S_COLLECT : S_IDLE;
      S_FAIL:
        state_nxt = S_FAIL;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it
  always_comb begin
    osc_nxt   = 1'b1;
    valid_nxt = 1'b0;
    fail_nxt  = 1'b0;
    case (state_nxt)
      S_WARMUP, S_COLLECT: osc_nxt = 1'b0;
      S_HOLD: begin
        osc_nxt   = 1'b0;
        valid_nxt = 1'b1;
      end
      S_FAIL:  fail_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], RAW_ENTROPY_IN};
  end

  // Divider and warmup count; both hold still in HOLD
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q  <= '0;
      warm_q <= '0;
    end else if (entering) begin
      div_q  <= '0;
      warm_q <= '0;
    end else if (tick) begin
      div_q <= '0;
      if (state_q == S_WARMUP) warm_q <= warm_q + WARM_W'(1);
    end else if (run) begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Repetition count; the first tick of each enable restarts the run at 1
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rep_q   <= '0;
      prev_q  <= 1'b0;
      first_q <= 1'b1;
    end else if (state_q == S_IDLE) begin
      first_q <= 1'b1;
    end else if (tick) begin
      rep_q   <= rep_nxt;
      prev_q  <= raw_s;
      first_q <= 1'b0;
    end
  end

  // Pairing, debias and word packing (first debiased bit lands in the MSB)
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q  <= 1'b0;
      a_q      <= 1'b0;
      bits_q   <= '0;
      shift_q  <= '0;
      WORD_OUT <= '0;
    end else begin
      if ((state_q == S_IDLE) || (state_q == S_FAIL) || xfer) begin
        phase_q <= 1'b0;
        bits_q  <= '0;
      end else if (tick && (state_q == S_COLLECT)) begin
        phase_q <= ~phase_q;
        if (!phase_q) a_q <= raw_s;
        if (bit_vld) begin
          shift_q <= shift_nxt;
          bits_q  <= word_done ? '0 : bits_q + BC_W'(1);
        end
      end
      if (state_nxt == S_FAIL)
        WORD_OUT <= '0;
      else if (word_done && (state_nxt == S_HOLD))
        WORD_OUT <= shift_nxt;
    end
  end

  a_hold_stable: assert property (@(posedge CLK) disable iff (RESET)
    (WORD_VALID && !WORD_READY) |=> (WORD_VALID && $stable(WORD_OUT)));

  a_fail_quiet: assert property (@(posedge CLK) disable iff (RESET)
    HEALTH_FAIL |-> (OSC_RESET && !WORD_VALID));

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler: instance a (DIV=1, no warmup) for debias/backpressure/health,
// instance b (DIV=8, WARMUP=2) against a sample-level debias model of a pre-generated source.
module tb_trng_sampler;

  localparam int HIST = 4096;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       a_en, a_raw, a_osc, a_valid, a_ready, a_fail;
  logic [7:0] a_word;
  logic       b_en, b_raw = 1'b0, b_osc, b_valid, b_ready, b_fail;
  logic [7:0] b_word;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   a_xfers = 0;
  logic hist [HIST];

  trng_sampler #(.WORD_W(8), .SAMPLE_DIV(1), .WARMUP(0), .REP_LIMIT(32)) dut_a (
    .CLK(CLK), .RESET(RESET), .ENABLE(a_en), .RAW_ENTROPY_IN(a_raw), .OSC_RESET(a_osc),
    .WORD_OUT(a_word), .WORD_VALID(a_valid), .WORD_READY(a_ready), .HEALTH_FAIL(a_fail));

  trng_sampler #(.WORD_W(8), .SAMPLE_DIV(8), .WARMUP(2), .REP_LIMIT(32)) dut_b (
    .CLK(CLK), .RESET(RESET), .ENABLE(b_en), .RAW_ENTROPY_IN(b_raw), .OSC_RESET(b_osc),
    .WORD_OUT(b_word), .WORD_VALID(b_valid), .WORD_READY(b_ready), .HEALTH_FAIL(b_fail));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) if (a_valid && a_ready) a_xfers <= a_xfers + 1;
  // Source b: bit hist[c] is driven throughout cycle c
  always @(negedge CLK) b_raw = hist[cyc % HIST];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Ticks of b fall on cycles base+8k; the sample taken there is the bit driven two cycles earlier.
  function automatic void model_word(input int base, input int k_start, input int nbits,
                                     output logic [7:0] w, output int t_last);
    int   k;
    int   n;
    logic sa, sb;
    k = k_start; n = 0; w = '0; t_last = 0;
    while ((n < nbits) && (k < 400)) begin
      sa = hist[(base + 8*k - 2) % HIST];
      sb = hist[(base + 8*(k+1) - 2) % HIST];
      if (sa != sb) begin
        w = {w[6:0], sa};
        n++;
        t_last = base + 8*(k+1);
      end
      k += 2;
    end
  endfunction

  task automatic wait_b_valid(input string tag, output int at);
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (b_valid) break;
    end
    chk(tag, b_valid, 1);
    at = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pat;
    logic [7:0]  w;
    int          e, t, v, base;

    for (int i = 0; i < HIST; i++) hist[i] = 1'($urandom_range(0, 1));
    RESET = 1; a_en = 0; a_raw = 0; a_ready = 0; b_en = 0; b_ready = 0;

    // Reset state
    step(3);
    chk("rst_osc", a_osc, 1);
    chk("rst_valid", a_valid, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_word", a_word, 0);
    chk("rst_b_osc", b_osc, 1);
    RESET = 0;

    // Debias: pairs 10,01,00,11,10,10,01,01,10,01 -> 10110010
    pat = 20'b10_01_00_11_10_10_01_01_10_01;
    @(negedge CLK); a_raw = pat[19];
    @(negedge CLK); a_raw = pat[18]; a_en = 1;
    chk("idle_osc", a_osc, 1);
    for (int i = 2; i < 20; i++) begin
      @(negedge CLK); a_raw = pat[19-i];
      if (i == 2) chk("en_osc", a_osc, 0);
    end
    step(2);
    chk("valid_early", a_valid, 0);
    step(1);
    chk("dbias_valid", a_valid, 1);
    chk("dbias_word", a_word, 8'hB2);

    // Backpressure, ENABLE dropped while holding: word still delivered, then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); a_raw = ~a_raw;
      if (i == 10) a_en = 0;
      chk("bp_valid", a_valid, 1);
      chk("bp_word", a_word, 8'hB2);
      chk("bp_osc", a_osc, 0);
    end
    a_ready = 1;
    @(negedge CLK); a_ready = 0;
    chk("xfer_drop", a_valid, 0);
    chk("xfer_count", a_xfers, 1);
    chk("hold_to_idle_osc", a_osc, 1);
    step(3);
    chk("xfer_once", a_xfers, 1);
    chk("idle_valid", a_valid, 0);

    // Stuck-at-1: trip one cycle after the 32nd tick
    a_raw = 1;
    step(3);
    a_en = 1;
    step(32);
    chk("stuck_pre_fail", a_fail, 0);
    chk("stuck_pre_osc", a_osc, 0);
    step(1);
    chk("stuck_fail", a_fail, 1);
    chk("stuck_osc", a_osc, 1);
    chk("stuck_valid", a_valid, 0);
    a_en = 0; step(2); a_en = 1; step(2);
    chk("fail_sticky", a_fail, 1);
    chk("fail_osc", a_osc, 1);
    RESET = 1; a_en = 0;
    step(1);
    RESET = 0;
    chk("rst_clr_fail", a_fail, 0);
    chk("rst_clr_osc", a_osc, 1);

    // ENABLE drop after 5 of 8 bits, then re-enable with full warmup
    step(2);
    e = cyc; b_en = 1;
    model_word(e, 3, 5, w, t);
    while (cyc < t + 1) @(negedge CLK);
    chk("mid_osc", b_osc, 0);
    chk("mid_valid", b_valid, 0);
    b_en = 0;
    step(1);
    chk("drop_osc", b_osc, 1);
    chk("drop_valid", b_valid, 0);
    step(5);
    e = cyc; b_en = 1;
    model_word(e, 3, 8, w, t);
    wait_b_valid("reen_valid", v);
    chk("reen_time", v, t + 1);
    chk("reen_word", b_word, w);
    b_ready = 1;

    // Back-to-back words with READY high: ticks every 8 cycles from each transfer
    base = v;
    for (int n = 0; n < 3; n++) begin
      model_word(base, 1, 8, w, t);
      wait_b_valid("rnd_valid", v);
      chk("rnd_time", v, t + 1);
      chk("rnd_word", b_word, w);
      chk("rnd_fail", b_fail, 0);
      base = v;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
